// File: rtl/muldiv_station.sv
// Reservation station in front of the single-cycle MUL/DIV unit: holds dispatched M-extension
// ops, snoops the CDB for missing operands and issues the oldest ready entry. Macro MULDIV_ISSUE_REG_EN adds an issue register.
module muldiv_station #(
  parameter int SIZE       = 4,
  parameter int TAG_WIDTH  = 6,
  parameter int NAME_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  disp_valid,
  output logic                  disp_ready,
  input  logic [NAME_WIDTH-1:0] disp_instr_name,
  input  logic [31:0]           disp_data_1,
  input  logic [31:0]           disp_data_2,
  input  logic                  disp_valid_1,
  input  logic                  disp_valid_2,
  input  logic [TAG_WIDTH-1:0]  disp_tag_1,
  input  logic [TAG_WIDTH-1:0]  disp_tag_2,
  input  logic [TAG_WIDTH-1:0]  disp_dest_tag,
  input  logic                  cdb_valid,
  input  logic [TAG_WIDTH-1:0]  cdb_tag,
  input  logic [31:0]           cdb_data,
  output logic                  issue_valid,
  input  logic                  issue_ready,
  output logic [NAME_WIDTH-1:0] issue_instr_name,
  output logic [31:0]           issue_data_1,
  output logic [31:0]           issue_data_2,
  output logic [TAG_WIDTH-1:0]  issue_dest_tag
);

  localparam int IDX_W = $clog2(SIZE);
  localparam logic [IDX_W-1:0] AGE_ONE = IDX_W'(1);

  logic [SIZE-1:0]       busy_q;
  logic [SIZE-1:0]       v1_q;
  logic [SIZE-1:0]       v2_q;
  logic [NAME_WIDTH-1:0] name_q [SIZE];
  logic [31:0]           d1_q   [SIZE];
  logic [31:0]           d2_q   [SIZE];
  logic [TAG_WIDTH-1:0]  t1_q   [SIZE];
  logic [TAG_WIDTH-1:0]  t2_q   [SIZE];
  logic [TAG_WIDTH-1:0]  dest_q [SIZE];
  logic [IDX_W-1:0]      age_q  [SIZE];

  logic [SIZE-1:0]  cand;
  logic [SIZE-1:0]  age_dn;
  logic             has_cand;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] sel_age;
  logic [IDX_W-1:0] free_idx;
  logic             disp_fire;
  logic             deq;
  logic             cap_1;
  logic             cap_2;

  assign disp_ready = ~&busy_q;
  assign disp_fire  = disp_valid && disp_ready && !flush;
  assign cand       = busy_q & v1_q & v2_q;
  assign cap_1      = !disp_valid_1 && cdb_valid && (cdb_tag == disp_tag_1);
  assign cap_2      = !disp_valid_2 && cdb_valid && (cdb_tag == disp_tag_2);

  // Ages are unique among busy entries, so the strict compare never ties.
  always_comb begin
    has_cand = 1'b0;
    sel_idx  = '0;
    sel_age  = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (cand[i] && (!has_cand || age_q[i] > sel_age)) begin
        has_cand = 1'b1;
        sel_idx  = IDX_W'(i);
        sel_age  = age_q[i];
      end
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = IDX_W'(i);
    end
  end

  always_comb begin
    age_dn = '0;
    for (int i = 0; i < SIZE; i++) begin
      age_dn[i] = deq && busy_q[i] && (age_q[i] > sel_age);
    end
  end

`ifdef MULDIV_ISSUE_REG_EN
  logic                  oreg_valid_q;
  logic [NAME_WIDTH-1:0] oreg_name_q;
  logic [31:0]           oreg_d1_q;
  logic [31:0]           oreg_d2_q;
  logic [TAG_WIDTH-1:0]  oreg_dest_q;

  // An entry leaves the station whenever the output stage is empty or drains this cycle.
  assign deq = has_cand && (!oreg_valid_q || issue_ready) && !flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      oreg_valid_q <= 1'b0;
      oreg_name_q  <= '0;
      oreg_d1_q    <= '0;
      oreg_d2_q    <= '0;
      oreg_dest_q  <= '0;
    end else if (flush) begin
      oreg_valid_q <= 1'b0;
      oreg_name_q  <= '0;
      oreg_d1_q    <= '0;
      oreg_d2_q    <= '0;
      oreg_dest_q  <= '0;
    end else if (deq) begin
      oreg_valid_q <= 1'b1;
      oreg_name_q  <= name_q[sel_idx];
      oreg_d1_q    <= d1_q[sel_idx];
      oreg_d2_q    <= d2_q[sel_idx];
      oreg_dest_q  <= dest_q[sel_idx];
    end else if (oreg_valid_q && issue_ready) begin
      oreg_valid_q <= 1'b0;
      oreg_name_q  <= '0;
      oreg_d1_q    <= '0;
      oreg_d2_q    <= '0;
      oreg_dest_q  <= '0;
    end
  end

  assign issue_valid      = oreg_valid_q && !flush;
  assign issue_instr_name = oreg_name_q;
  assign issue_data_1     = oreg_d1_q;
  assign issue_data_2     = oreg_d2_q;
  assign issue_dest_tag   = oreg_dest_q;
`else
  assign deq = has_cand && issue_ready && !flush;

  always_comb begin
    issue_valid      = has_cand && !flush;
    issue_instr_name = '0;
    issue_data_1     = '0;
    issue_data_2     = '0;
    issue_dest_tag   = '0;
    if (has_cand) begin
      issue_instr_name = name_q[sel_idx];
      issue_data_1     = d1_q[sel_idx];
      issue_data_2     = d2_q[sel_idx];
      issue_dest_tag   = dest_q[sel_idx];
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= '0;
      v1_q   <= '0;
      v2_q   <= '0;
      for (int i = 0; i < SIZE; i++) begin
        name_q[i] <= '0;
        d1_q[i]   <= '0;
        d2_q[i]   <= '0;
        t1_q[i]   <= '0;
        t2_q[i]   <= '0;
        dest_q[i] <= '0;
        age_q[i]  <= '0;
      end
    end else if (flush) begin
      busy_q <= '0;
    end else begin
      for (int i = 0; i < SIZE; i++) begin
        if (busy_q[i]) begin
          if (deq && (IDX_W'(i) == sel_idx)) begin
            busy_q[i] <= 1'b0;
          end else if (disp_fire && !age_dn[i]) begin
            age_q[i] <= age_q[i] + AGE_ONE;
          end else if (!disp_fire && age_dn[i]) begin
            age_q[i] <= age_q[i] - AGE_ONE;
          end
          if (!v1_q[i] && cdb_valid && (t1_q[i] == cdb_tag)) begin
            d1_q[i] <= cdb_data;
            v1_q[i] <= 1'b1;
          end
          if (!v2_q[i] && cdb_valid && (t2_q[i] == cdb_tag)) begin
            d2_q[i] <= cdb_data;
            v2_q[i] <= 1'b1;
          end
        end else if (disp_fire && (IDX_W'(i) == free_idx)) begin
          busy_q[i] <= 1'b1;
          age_q[i]  <= '0;
          name_q[i] <= disp_instr_name;
          t1_q[i]   <= disp_tag_1;
          t2_q[i]   <= disp_tag_2;
          dest_q[i] <= disp_dest_tag;
          d1_q[i]   <= cap_1 ? cdb_data : disp_data_1;
          d2_q[i]   <= cap_2 ? cdb_data : disp_data_2;
          v1_q[i]   <= disp_valid_1 || cap_1;
          v2_q[i]   <= disp_valid_2 || cap_2;
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_station.sv
// Bench for muldiv_station: directed scenarios plus random traffic checked against a queue-based
// model where the oldest ready instruction is simply the first ready element of the queue.
module tb_muldiv_station;

  localparam int SIZE = 4;
  localparam int TW   = 6;
  localparam int NW   = 8;
`ifdef MULDIV_ISSUE_REG_EN
  localparam int LAT  = 1;
  localparam int REG  = 1;
`else
  localparam int LAT  = 0;
  localparam int REG  = 0;
`endif

  localparam logic [NW-1:0] MUL = 8'd0, MULH = 8'd1, MULHU = 8'd3;
  localparam logic [NW-1:0] DIV = 8'd4, DIVU = 8'd5, REM = 8'd6;

  logic clk = 1'b0;
  logic reset_n;
  logic flush, disp_valid, disp_ready;
  logic [NW-1:0] disp_instr_name;
  logic [31:0] disp_data_1, disp_data_2;
  logic disp_valid_1, disp_valid_2;
  logic [TW-1:0] disp_tag_1, disp_tag_2, disp_dest_tag;
  logic cdb_valid;
  logic [TW-1:0] cdb_tag;
  logic [31:0] cdb_data;
  logic issue_valid, issue_ready;
  logic [NW-1:0] issue_instr_name;
  logic [31:0] issue_data_1, issue_data_2;
  logic [TW-1:0] issue_dest_tag;

  always #5 clk = ~clk;

  muldiv_station #(.SIZE(SIZE), .TAG_WIDTH(TW), .NAME_WIDTH(NW)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_instr_name(disp_instr_name),
    .disp_data_1(disp_data_1), .disp_data_2(disp_data_2),
    .disp_valid_1(disp_valid_1), .disp_valid_2(disp_valid_2),
    .disp_tag_1(disp_tag_1), .disp_tag_2(disp_tag_2), .disp_dest_tag(disp_dest_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_instr_name(issue_instr_name),
    .issue_data_1(issue_data_1), .issue_data_2(issue_data_2), .issue_dest_tag(issue_dest_tag)
  );

  typedef struct packed {
    logic [NW-1:0] name;
    logic [31:0]   d1;
    logic [31:0]   d2;
    logic          v1;
    logic          v2;
    logic [TW-1:0] t1;
    logic [TW-1:0] t2;
    logic [TW-1:0] dest;
  } ent_t;

  ent_t q[$];
  ent_t rg;
  bit   rv;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int find_cand();
    for (int i = 0; i < q.size(); i++)
      if (q[i].v1 && q[i].v2) return i;
    return -1;
  endfunction

  task automatic model_check();
    int k;
    ent_t e;
    if (!reset_n) return;
    k = find_cand();
    chk("disp_ready", {31'd0, disp_ready}, {31'd0, q.size() < SIZE});
`ifdef MULDIV_ISSUE_REG_EN
    chk("issue_valid", {31'd0, issue_valid}, {31'd0, rv && !flush});
    e = rg;
`else
    chk("issue_valid", {31'd0, issue_valid}, {31'd0, (k >= 0) && !flush});
    e = (k >= 0) ? q[k] : '0;
`endif
    chk("issue_name", {24'd0, issue_instr_name}, {24'd0, e.name});
    chk("issue_data_1", issue_data_1, e.d1);
    chk("issue_data_2", issue_data_2, e.d2);
    chk("issue_dest", {26'd0, issue_dest_tag}, {26'd0, e.dest});
  endtask

  task automatic model_update();
    int k;
    int pre;
    ent_t n;
    if (!reset_n || flush) begin
      q.delete();
      rv = 0;
      rg = '0;
      return;
    end
    pre = q.size();
    k = find_cand();
`ifdef MULDIV_ISSUE_REG_EN
    if (k >= 0 && (!rv || issue_ready)) begin
      rg = q[k];
      rv = 1;
      q.delete(k);
    end else if (rv && issue_ready) begin
      rv = 0;
      rg = '0;
    end
`else
    if (k >= 0 && issue_ready) q.delete(k);
`endif
    if (cdb_valid) begin
      for (int i = 0; i < q.size(); i++) begin
        if (!q[i].v1 && q[i].t1 == cdb_tag) begin q[i].d1 = cdb_data; q[i].v1 = 1'b1; end
        if (!q[i].v2 && q[i].t2 == cdb_tag) begin q[i].d2 = cdb_data; q[i].v2 = 1'b1; end
      end
    end
    if (disp_valid && pre < SIZE) begin
      n.name = disp_instr_name;
      n.t1 = disp_tag_1;
      n.t2 = disp_tag_2;
      n.dest = disp_dest_tag;
      n.v1 = disp_valid_1 || (cdb_valid && cdb_tag == disp_tag_1);
      n.v2 = disp_valid_2 || (cdb_valid && cdb_tag == disp_tag_2);
      n.d1 = (!disp_valid_1 && cdb_valid && cdb_tag == disp_tag_1) ? cdb_data : disp_data_1;
      n.d2 = (!disp_valid_2 && cdb_valid && cdb_tag == disp_tag_2) ? cdb_data : disp_data_2;
      q.push_back(n);
    end
  endtask

  task automatic to_neg();
    @(negedge clk);
    model_check();
  endtask

  task automatic to_next();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic step();
    to_neg();
    to_next();
  endtask

  task automatic idle_inputs();
    flush = 0; disp_valid = 0; disp_instr_name = '0;
    disp_data_1 = '0; disp_data_2 = '0; disp_valid_1 = 0; disp_valid_2 = 0;
    disp_tag_1 = '0; disp_tag_2 = '0; disp_dest_tag = '0;
    cdb_valid = 0; cdb_tag = '0; cdb_data = '0; issue_ready = 0;
  endtask

  task automatic set_disp(input logic [NW-1:0] nm, input logic [31:0] a, input logic va,
                          input logic [TW-1:0] ta, input logic [31:0] b, input logic vb,
                          input logic [TW-1:0] tb, input logic [TW-1:0] dt);
    disp_valid = 1; disp_instr_name = nm;
    disp_data_1 = a; disp_valid_1 = va; disp_tag_1 = ta;
    disp_data_2 = b; disp_valid_2 = vb; disp_tag_2 = tb;
    disp_dest_tag = dt;
  endtask

  // Waits (bounded) for issue_valid, checks latency and fields, then takes the handshake edge.
  task automatic wait_issue(input string nm, input int lat, input logic [NW-1:0] en,
                            input logic [31:0] a, input logic [31:0] b, input logic [TW-1:0] dt);
    int c;
    c = 0;
    to_neg();
    while (!issue_valid && c < 12) begin
      to_next();
      to_neg();
      c++;
    end
    chk({nm, "_lat"}, c, lat);
    chk({nm, "_name"}, {24'd0, issue_instr_name}, {24'd0, en});
    chk({nm, "_d1"}, issue_data_1, a);
    chk({nm, "_d2"}, issue_data_2, b);
    chk({nm, "_dest"}, {26'd0, issue_dest_tag}, {26'd0, dt});
    to_next();
  endtask

  task automatic rand_inputs();
    disp_valid = ($urandom_range(0, 1) == 1);
    disp_instr_name = NW'($urandom_range(0, 7));
    disp_data_1 = $urandom; disp_data_2 = $urandom;
    disp_valid_1 = ($urandom_range(0, 2) != 0);
    disp_valid_2 = ($urandom_range(0, 2) != 0);
    disp_tag_1 = TW'($urandom_range(0, 7));
    disp_tag_2 = TW'($urandom_range(0, 7));
    disp_dest_tag = TW'($urandom_range(0, 63));
    cdb_valid = ($urandom_range(0, 1) == 1);
    cdb_tag = TW'($urandom_range(0, 7));
    cdb_data = $urandom;
    issue_ready = ($urandom_range(0, 3) != 0);
    flush = ($urandom_range(0, 39) == 0);
  endtask

  initial begin
    reset_n = 0;
    idle_inputs();
    rv = 0;
    rg = '0;
    #2;
    chk("rst_issue_valid", {31'd0, issue_valid}, 32'd0);
    chk("rst_issue_data_1", issue_data_1, 32'd0);
    chk("rst_issue_name", {24'd0, issue_instr_name}, 32'd0);
    chk("rst_disp_ready", {31'd0, disp_ready}, 32'd1);
    #20 reset_n = 1;
    @(posedge clk); #1;

    // MUL 7*6 with both operands ready
    issue_ready = 1;
    set_disp(MUL, 32'd7, 1, '0, 32'd6, 1, '0, 6'd1);
    step();
    disp_valid = 0;
    wait_issue("mul", LAT, MUL, 32'd7, 32'd6, 6'd1);
    to_neg();
    chk("mul_freed_ready", {31'd0, disp_ready}, 32'd1);
    chk("mul_freed_valid", {31'd0, issue_valid}, 32'd0);
    to_next();

    // DIV waiting on tag 5, broadcast two cycles after dispatch
    set_disp(DIV, 32'd0, 0, 6'd5, 32'd3, 1, '0, 6'd2);
    step();
    disp_valid = 0;
    step();
    cdb_valid = 1; cdb_tag = 6'd5; cdb_data = 32'h15;
    step();
    cdb_valid = 0;
    wait_issue("div_cdb", LAT, DIV, 32'h15, 32'd3, 6'd2);

    // capture of the awaited tag in the dispatch cycle
    set_disp(REM, 32'd100, 1, '0, 32'd0, 0, 6'd9, 6'd3);
    cdb_valid = 1; cdb_tag = 6'd9; cdb_data = 32'h33;
    step();
    disp_valid = 0; cdb_valid = 0;
    wait_issue("rem_samecyc", LAT, REM, 32'd100, 32'h33, 6'd3);

    // fill the station with issue stalled, offer one more, then drain in order
    issue_ready = 0;
    for (int k = 0; k < SIZE + REG; k++) begin
      set_disp(MULH, 32'(k), 1, '0, 32'(10 + k), 1, '0, TW'(k));
      step();
    end
    set_disp(MULH, 32'd99, 1, '0, 32'd99, 1, '0, 6'd63);
    to_neg();
    chk("full_disp_ready", {31'd0, disp_ready}, 32'd0);
    to_next();
    disp_valid = 0;
    issue_ready = 1;
    for (int k = 0; k < SIZE + REG; k++)
      wait_issue("order", 0, MULH, 32'(k), 32'(10 + k), TW'(k));
    to_neg();
    chk("full_no_extra", {31'd0, issue_valid}, 32'd0);
    to_next();

    // older waiting entry is bypassed by a younger ready one
    set_disp(MULHU, 32'd0, 0, 6'd12, 32'd5, 1, '0, 6'd20);
    step();
    set_disp(DIVU, 32'd50, 1, '0, 32'd7, 1, '0, 6'd21);
    step();
    disp_valid = 0;
    wait_issue("young_first", LAT, DIVU, 32'd50, 32'd7, 6'd21);
    cdb_valid = 1; cdb_tag = 6'd12; cdb_data = 32'h40;
    step();
    cdb_valid = 0;
    wait_issue("old_after", LAT, MULHU, 32'h40, 32'd5, 6'd20);

    // flush with three busy entries
    issue_ready = 0;
    for (int k = 0; k < 3; k++) begin
      set_disp(MUL, 32'(k + 1), 1, '0, 32'd2, 1, '0, TW'(40 + k));
      step();
    end
    disp_valid = 0;
    flush = 1; issue_ready = 1;
    to_neg();
    chk("flush_issue_valid", {31'd0, issue_valid}, 32'd0);
    to_next();
    flush = 0;
    to_neg();
    chk("post_flush_ready", {31'd0, disp_ready}, 32'd1);
    chk("post_flush_valid", {31'd0, issue_valid}, 32'd0);
    to_next();
    step();

    for (int c = 0; c < 1500; c++) begin
      rand_inputs();
      step();
    end

    // asynchronous reset in the middle of traffic
    idle_inputs();
    #2 reset_n = 0;
    #1;
    chk("async_rst_valid", {31'd0, issue_valid}, 32'd0);
    chk("async_rst_data_2", issue_data_2, 32'd0);
    chk("async_rst_dest", {26'd0, issue_dest_tag}, 32'd0);
    q.delete(); rv = 0; rg = '0;
    to_neg();
    #2 reset_n = 1;
    to_next();

    for (int c = 0; c < 500; c++) begin
      rand_inputs();
      step();
    end
    idle_inputs();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
